dct_1d_pipe: RTL

DCT_1D_PIPE -- requirements
Module: dct_1d_pipe

---
 rtl/dct_1d_pipe_if.sv | 26 ++
 rtl/dct_1d_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dct_1d_pipe_if.sv
// Stream bundle for the 1-D 8-point DCT pipeline: sample input side (s_*)
// and coefficient output side (m_*). The design sits on the slave modport;
// the environment drives through the master modport.
interface dct_1d_pipe_if #(
    parameter int INPUT_W = 8,
    parameter int OUT_W   = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic [INPUT_W-1:0]      s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] m_data;
    logic [2:0]              m_idx;
    logic                    m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_idx, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_idx, m_last
    );
endinterface

// File: rtl/dct_1d_pipe.sv
// 8-point 1-D DCT, multiplier-free shift/add butterfly, four pipeline stages:
// row buffer -> reg A (butterflies + rotation) -> reg B (final butterflies)
// -> output buffer that serialises y0..y7 one beat per cycle.
module dct_1d_pipe #(
    parameter int INPUT_W   = 8,
    parameter int OUT_W     = 16,
    parameter int SIGNED_IN = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    dct_1d_pipe_if.slave   bus
);
    localparam int W = INPUT_W + 5;
    typedef logic signed [W-1:0]     word_t;
    typedef logic signed [OUT_W-1:0] coef_t;

    localparam word_t OFFSET = word_t'(1'b1) <<< (INPUT_W - 1);

    // Map a raw sample into the signed internal domain.
    function automatic word_t level_shift(input logic [INPUT_W-1:0] d);
        word_t v;
        if (SIGNED_IN != 32'sd0) v = word_t'($signed(d));
        else                     v = word_t'({5'b00000, d}) - OFFSET;
        return v;
    endfunction

    // Row buffer
    word_t      row_r [8];
    logic [2:0] cnt_r;
    logic       row_full_r;
    // Reg A: a0..a4, b5, b6, a7
    word_t      a_r [8];
    logic       a_v_r;
    // Reg B: y0..y7
    word_t      b_r [8];
    logic       b_v_r;
    // Output buffer
    coef_t      obuf_r [8];
    logic [2:0] rd_ptr_r;
    logic       o_v_r;
    coef_t      m_data_r;
    logic       m_last_r;

    logic  o_xfer_s, o_free_s, b_move_s, b_free_s, a_move_s, a_free_s;
    logic  row_move_s, s_ready_s, accept_s;
    word_t a_next_s [8];
    word_t c_s [8];
    word_t y_s [8];

    // A stage may load when it is empty or its contents leave this cycle;
    // the chain is combinational from the output buffer back to s_ready.
    assign o_xfer_s   = o_v_r && bus.m_ready;
    assign o_free_s   = !o_v_r || (o_xfer_s && (rd_ptr_r == 3'd7));
    assign b_move_s   = b_v_r && o_free_s;
    assign b_free_s   = !b_v_r || b_move_s;
    assign a_move_s   = a_v_r && b_free_s;
    assign a_free_s   = !a_v_r || a_move_s;
    assign row_move_s = row_full_r && a_free_s;
    assign s_ready_s  = !row_full_r || row_move_s;
    assign accept_s   = bus.s_valid && s_ready_s;

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = o_v_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_idx   = rd_ptr_r;
    assign bus.m_last  = m_last_r;

    // Stages 1 and 2: input butterflies and the odd-part shift/add rotation.
    always_comb begin
        a_next_s[0] = row_r[0] + row_r[7];
        a_next_s[1] = row_r[1] + row_r[6];
        a_next_s[2] = row_r[2] + row_r[5];
        a_next_s[3] = row_r[3] + row_r[4];
        a_next_s[4] = row_r[3] - row_r[4];
        a_next_s[7] = row_r[0] - row_r[7];
        // a5 = x2-x5, a6 = x1-x6; slot 6 carries b6, slot 5 carries b5
        a_next_s[6] = (row_r[1] - row_r[6]) + ((row_r[2] - row_r[5]) >>> 3'd3)
                    + ((row_r[2] - row_r[5]) >>> 3'd2);
        a_next_s[5] = (a_next_s[6] >>> 3'd1) + (a_next_s[6] >>> 3'd3)
                    - (row_r[2] - row_r[5]);
    end

    // Stages 3 and 4: second butterfly layer and output lifting steps.
    always_comb begin
        c_s[0] = a_r[0] + a_r[3];
        c_s[1] = a_r[1] + a_r[2];
        c_s[2] = a_r[1] - a_r[2];
        c_s[3] = a_r[0] - a_r[3];
        c_s[4] = a_r[4] + a_r[5];
        c_s[5] = a_r[4] - a_r[5];
        c_s[6] = a_r[7] - a_r[6];
        c_s[7] = a_r[7] + a_r[6];
        y_s[0] = c_s[0] + c_s[1];
        y_s[1] = (y_s[0] >>> 3'd1) - c_s[1];
        y_s[2] = (c_s[3] >>> 3'd3) + (c_s[3] >>> 3'd2) - c_s[2];
        y_s[3] = (y_s[2] >>> 3'd3) + (y_s[2] >>> 3'd2) + c_s[3];
        y_s[4] = (c_s[7] >>> 3'd3) - c_s[4];
        y_s[5] = (c_s[6] >>> 3'd3) + (c_s[6] >>> 3'd2) + (c_s[6] >>> 3'd1) + c_s[5];
        y_s[6] = (y_s[5] >>> 3'd1) - c_s[6];
        y_s[7] = c_s[7];
    end

    // Row buffer: collect eight samples; a full row waits until reg A takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) row_r[i] <= '0;
            cnt_r      <= 3'd0;
            row_full_r <= 1'b0;
        end else if (clr) begin
            cnt_r      <= 3'd0;
            row_full_r <= 1'b0;
        end else begin
            if (row_move_s) row_full_r <= 1'b0;
            if (accept_s) begin
                row_r[cnt_r] <= level_shift(bus.s_data);
                cnt_r        <= cnt_r + 3'd1;
                if (cnt_r == 3'd7) row_full_r <= 1'b1;
            end
        end
    end

    // Reg A and reg B with their valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                a_r[i] <= '0;
                b_r[i] <= '0;
            end
            a_v_r <= 1'b0;
            b_v_r <= 1'b0;
        end else if (clr) begin
            a_v_r <= 1'b0;
            b_v_r <= 1'b0;
        end else begin
            if (row_move_s) begin
                a_r   <= a_next_s;
                a_v_r <= 1'b1;
            end else if (a_move_s) begin
                a_v_r <= 1'b0;
            end
            if (a_move_s) begin
                b_r   <= y_s;
                b_v_r <= 1'b1;
            end else if (b_move_s) begin
                b_v_r <= 1'b0;
            end
        end
    end

    // Output buffer: reload on the index-7 beat so consecutive rows have no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) obuf_r[i] <= '0;
            o_v_r    <= 1'b0;
            rd_ptr_r <= 3'd0;
            m_data_r <= '0;
            m_last_r <= 1'b0;
        end else if (clr) begin
            o_v_r    <= 1'b0;
            rd_ptr_r <= 3'd0;
            m_data_r <= '0;
            m_last_r <= 1'b0;
        end else if (b_move_s) begin
            for (int i = 0; i < 8; i++) obuf_r[i] <= coef_t'(b_r[i]);
            o_v_r    <= 1'b1;
            rd_ptr_r <= 3'd0;
            m_data_r <= coef_t'(b_r[0]);
            m_last_r <= 1'b0;
        end else if (o_xfer_s) begin
            if (rd_ptr_r == 3'd7) begin
                o_v_r    <= 1'b0;
                rd_ptr_r <= 3'd0;
                m_data_r <= '0;
                m_last_r <= 1'b0;
            end else begin
                rd_ptr_r <= rd_ptr_r + 3'd1;
                m_data_r <= obuf_r[rd_ptr_r + 3'd1];
                m_last_r <= (rd_ptr_r == 3'd6);
            end
        end
    end
endmodule
